// File: rtl/onehot_index_tracker_pkg.sv
// Shared definitions for the one-hot detector family: default width, index type
// and the reference one-hot predicate.
package onehot_pkg;
   localparam int ONEHOT_DATA_WIDTH = 32;
   localparam int ONEHOT_IDX_WIDTH  = $clog2(ONEHOT_DATA_WIDTH);

   typedef logic [ONEHOT_IDX_WIDTH-1:0] idx_t;

   function automatic logic is_onehot(input logic [ONEHOT_DATA_WIDTH-1:0] d);
      logic [ONEHOT_DATA_WIDTH-1:0] dm1;
      dm1 = d - {{(ONEHOT_DATA_WIDTH-1){1'b0}}, 1'b1};
      return (d != {ONEHOT_DATA_WIDTH{1'b0}}) && ((d & dm1) == {ONEHOT_DATA_WIDTH{1'b0}});
   endfunction
endpackage

// File: rtl/onehot_index_tracker_if.sv
// Sample/result bundle between the one-hot detector stage and the index tracker.
interface onehot_index_tracker_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   localparam int IDX_WIDTH = $clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] din;
   logic                  onehot;
   logic                  din_valid;
   logic                  clear;
   logic                  out_valid;
   logic [IDX_WIDTH-1:0]  out_idx;
   logic                  out_onehot;
   logic                  out_changed;
   logic [CNT_WIDTH-1:0]  err_count;
   logic                  alarm;
   logic                  mismatch;

   modport master (
      output din, onehot, din_valid, clear,
      input  out_valid, out_idx, out_onehot, out_changed, err_count, alarm, mismatch
   );

   modport slave (
      input  din, onehot, din_valid, clear,
      output out_valid, out_idx, out_onehot, out_changed, err_count, alarm, mismatch
   );
endinterface

// File: rtl/onehot_index_tracker_idx_enc.sv
// Combinational lowest-set-bit encoder with local one-hot verdict.
module onehot_idx_enc
   import onehot_pkg::*;
#(
   parameter int DATA_WIDTH = ONEHOT_DATA_WIDTH,
   parameter int IDX_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] din,
   output logic [IDX_WIDTH-1:0]  idx,
   output logic                  onehot_local
);
   logic [DATA_WIDTH-1:0] din_m1_s;

   assign din_m1_s     = din - {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   assign onehot_local = (din != {DATA_WIDTH{1'b0}}) && ((din & din_m1_s) == {DATA_WIDTH{1'b0}});

   // Priority encode: scanning down from the MSB leaves the lowest set bit last.
   always_comb begin
      idx = {IDX_WIDTH{1'b0}};
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         if (din[i]) begin
            idx = IDX_WIDTH'(i);
         end else begin
            idx = idx;
         end
      end
   end
endmodule

// File: rtl/onehot_index_tracker.sv
// Registers the encoded index of each valid sample, flags index changes and keeps
// saturating violation statistics with sticky alarm/mismatch flags.
module onehot_index_tracker
   import onehot_pkg::*;
#(
   parameter int DATA_WIDTH = ONEHOT_DATA_WIDTH,
   parameter int ERR_THRESH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input logic                  clk,
   input logic                  resetn,
   onehot_index_tracker_if.slave bus
);
   localparam int IDX_WIDTH = $clog2(DATA_WIDTH);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   endfunction

   logic [IDX_WIDTH-1:0] idx_s;
   logic                 onehot_local_s;

   logic                 out_valid_r,   out_valid_s;
   logic [IDX_WIDTH-1:0] out_idx_r,     out_idx_s;
   logic                 out_onehot_r,  out_onehot_s;
   logic                 out_changed_r, out_changed_s;
   logic [CNT_WIDTH-1:0] err_count_r,   err_count_s;
   logic                 alarm_r,       alarm_s;
   logic                 mismatch_r,    mismatch_s;
   logic [CNT_WIDTH-1:0] run_cnt_r,     run_cnt_s;
   logic [IDX_WIDTH-1:0] last_idx_r,    last_idx_s;
   logic                 last_vld_r,    last_vld_s;

   onehot_idx_enc #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_enc (
      .din          (bus.din),
      .idx          (idx_s),
      .onehot_local (onehot_local_s)
   );

   // Next-state: clear is applied first, then any same-cycle sample is folded in.
   always_comb begin
      out_valid_s   = 1'b0;
      out_idx_s     = out_idx_r;
      out_onehot_s  = out_onehot_r;
      out_changed_s = 1'b0;
      last_idx_s    = last_idx_r;
      if (bus.clear) begin
         err_count_s = {CNT_WIDTH{1'b0}};
         run_cnt_s   = {CNT_WIDTH{1'b0}};
         alarm_s     = 1'b0;
         mismatch_s  = 1'b0;
         last_vld_s  = 1'b0;
      end else begin
         err_count_s = err_count_r;
         run_cnt_s   = run_cnt_r;
         alarm_s     = alarm_r;
         mismatch_s  = mismatch_r;
         last_vld_s  = last_vld_r;
      end

      if (bus.din_valid) begin
         out_valid_s  = 1'b1;
         out_idx_s    = idx_s;
         out_onehot_s = onehot_local_s;
         if (onehot_local_s) begin
            out_changed_s = last_vld_s && (idx_s != last_idx_r);
            last_idx_s    = idx_s;
            last_vld_s    = 1'b1;
            run_cnt_s     = {CNT_WIDTH{1'b0}};
         end else begin
            run_cnt_s   = sat_inc(run_cnt_s);
            err_count_s = sat_inc(err_count_s);
         end
         alarm_s    = alarm_s | (run_cnt_s == CNT_WIDTH'(ERR_THRESH));
         mismatch_s = mismatch_s | (bus.onehot != onehot_local_s);
      end else begin
         out_valid_s = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_r   <= 1'b0;
         out_idx_r     <= {IDX_WIDTH{1'b0}};
         out_onehot_r  <= 1'b0;
         out_changed_r <= 1'b0;
         err_count_r   <= {CNT_WIDTH{1'b0}};
         alarm_r       <= 1'b0;
         mismatch_r    <= 1'b0;
         run_cnt_r     <= {CNT_WIDTH{1'b0}};
         last_idx_r    <= {IDX_WIDTH{1'b0}};
         last_vld_r    <= 1'b0;
      end else begin
         out_valid_r   <= out_valid_s;
         out_idx_r     <= out_idx_s;
         out_onehot_r  <= out_onehot_s;
         out_changed_r <= out_changed_s;
         err_count_r   <= err_count_s;
         alarm_r       <= alarm_s;
         mismatch_r    <= mismatch_s;
         run_cnt_r     <= run_cnt_s;
         last_idx_r    <= last_idx_s;
         last_vld_r    <= last_vld_s;
      end
   end

   assign bus.out_valid   = out_valid_r;
   assign bus.out_idx     = out_idx_r;
   assign bus.out_onehot  = out_onehot_r;
   assign bus.out_changed = out_changed_r;
   assign bus.err_count   = err_count_r;
   assign bus.alarm       = alarm_r;
   assign bus.mismatch    = mismatch_r;
endmodule

// File: tb/tb_onehot_index_tracker.sv
// Bench for onehot_index_tracker: directed vector table, asynchronous reset
// sequence, then random samples against a behavioural model.
module tb_onehot_index_tracker;
   localparam int DW = 32;
   localparam int CW = 16;
   localparam int TH = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   typedef struct packed {
      logic        v;
      logic [4:0]  idx;
      logic        oh;
      logic        ch;
      logic [15:0] err;
      logic        al;
      logic        mm;
   } obs_t;

   typedef struct {
      logic [31:0] din;
      logic        oh;
      logic        v;
      logic        clr;
      obs_t        exp;
   } vec_t;

   logic clk = 1'b0;
   logic resetn;
   int   vectors = 0;
   int   miscompares = 0;
   vec_t tbl[$];

   // model state
   int   m_err, m_run, m_last_idx;
   bit   m_last_vld, m_alarm, m_mm;
   obs_t m_out;

   onehot_index_tracker_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   onehot_index_tracker #(
      .DATA_WIDTH (DW),
      .ERR_THRESH (TH),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o.v   = bus.out_valid;
      o.idx = bus.out_idx;
      o.oh  = bus.out_onehot;
      o.ch  = bus.out_changed;
      o.err = bus.err_count;
      o.al  = bus.alarm;
      o.mm  = bus.mismatch;
      return o;
   endfunction

   function automatic obs_t mk(int v, int idx, int oh, int ch, int err, int al, int mm);
      obs_t o;
      o.v = v[0]; o.idx = idx[4:0]; o.oh = oh[0]; o.ch = ch[0];
      o.err = err[15:0]; o.al = al[0]; o.mm = mm[0];
      return o;
   endfunction

   task automatic add(input logic [31:0] din, input int oh, input int v, input int clr, input obs_t exp);
      vec_t r;
      r.din = din; r.oh = oh[0]; r.v = v[0]; r.clr = clr[0]; r.exp = exp;
      tbl.push_back(r);
   endtask

   task automatic check(input string name, input obs_t exp);
      obs_t got;
      got = sample();
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got v=%0b idx=%0d oh=%0b ch=%0b err=%0d al=%0b mm=%0b, expected v=%0b idx=%0d oh=%0b ch=%0b err=%0d al=%0b mm=%0b",
                  name, got.v, got.idx, got.oh, got.ch, got.err, got.al, got.mm,
                  exp.v, exp.idx, exp.oh, exp.ch, exp.err, exp.al, exp.mm);
      end
   endtask

   task automatic drive(input logic [31:0] din, input logic oh, input logic v, input logic clr);
      @(negedge clk);
      bus.din = din; bus.onehot = oh; bus.din_valid = v; bus.clear = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_err = 0; m_run = 0; m_last_idx = 0;
      m_last_vld = 1'b0; m_alarm = 1'b0; m_mm = 1'b0;
      m_out = '0;
   endtask

   // Reference behaviour from the rules: lowest set bit via d & -d, one-hot via popcount.
   task automatic model_step(input logic [31:0] din, input logic oh, input logic v, input logic clr);
      logic [31:0] lsb;
      int          idx;
      bit          loc;
      if (clr) begin
         m_err = 0; m_run = 0; m_alarm = 1'b0; m_mm = 1'b0; m_last_vld = 1'b0;
      end
      m_out.v  = v;
      m_out.ch = 1'b0;
      if (v) begin
         lsb = din & (~din + 32'd1);
         idx = $clog2(lsb);
         loc = ($countones(din) == 1);
         m_out.idx = idx[4:0];
         m_out.oh  = loc;
         if (loc) begin
            m_out.ch   = m_last_vld && (idx != m_last_idx);
            m_last_idx = idx;
            m_last_vld = 1'b1;
            m_run      = 0;
         end else begin
            m_run = (m_run < CNT_MAX) ? m_run + 1 : CNT_MAX;
            m_err = (m_err < CNT_MAX) ? m_err + 1 : CNT_MAX;
         end
         if (m_run == TH) m_alarm = 1'b1;
         if (oh != loc) m_mm = 1'b1;
      end
      m_out.err = m_err[15:0];
      m_out.al  = m_alarm;
      m_out.mm  = m_mm;
   endtask

   initial begin
      logic [31:0] d;
      logic        o, v, c;
      int          sel;

      resetn = 1'b0;
      bus.din = 32'd0; bus.onehot = 1'b0; bus.din_valid = 1'b0; bus.clear = 1'b0;

      //            din           oh v  clr       v idx oh ch err al mm
      add(32'h0000ffff, 0, 1, 0, mk(1,  0, 0, 0, 1, 0, 0));
      add(32'd4,        1, 1, 0, mk(1,  2, 1, 0, 1, 0, 0));
      add(32'd1,        1, 1, 0, mk(1,  0, 1, 1, 1, 0, 0));
      add(32'd0,        0, 0, 1, mk(0,  0, 1, 0, 0, 0, 0));
      add(32'h3,        0, 1, 0, mk(1,  0, 0, 0, 1, 0, 0));
      add(32'h0,        0, 1, 0, mk(1,  0, 0, 0, 2, 0, 0));
      add(32'hffff,     0, 1, 0, mk(1,  0, 0, 0, 3, 0, 0));
      add(32'h5,        0, 1, 0, mk(1,  0, 0, 0, 4, 1, 0));
      add(32'h8,        1, 1, 0, mk(1,  3, 1, 0, 4, 1, 0));
      add(32'h10,       0, 1, 0, mk(1,  4, 1, 1, 4, 1, 1));
      add(32'h0,        0, 0, 0, mk(0,  4, 1, 0, 4, 1, 1));
      add(32'h3,        0, 1, 1, mk(1,  0, 0, 0, 1, 0, 0));
      add(32'h80000000, 1, 1, 0, mk(1, 31, 1, 0, 1, 0, 0));
      add(32'h0,        0, 0, 0, mk(0, 31, 1, 0, 1, 0, 0));
      add(32'h80000000, 1, 1, 0, mk(1, 31, 1, 0, 1, 0, 0));
      add(32'h0,        0, 0, 0, mk(0, 31, 1, 0, 1, 0, 0));
      add(32'h80000000, 1, 1, 0, mk(1, 31, 1, 0, 1, 0, 0));

      #2;
      check("reset_state", mk(0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].din, tbl[i].oh, tbl[i].v, tbl[i].clr);
         check($sformatf("table_row%0d", i), tbl[i].exp);
      end

      // asynchronous reset in the middle of a violation run
      drive(32'h3, 1'b0, 1'b1, 1'b1);
      check("run_a", mk(1, 0, 0, 0, 1, 0, 0));
      drive(32'h3, 1'b0, 1'b1, 1'b0);
      check("run_b", mk(1, 0, 0, 0, 2, 0, 0));
      drive(32'h0, 1'b0, 1'b1, 1'b0);
      check("run_c_err3", mk(1, 0, 0, 0, 3, 0, 0));
      @(negedge clk);
      bus.din_valid = 1'b0; bus.clear = 1'b0;
      resetn = 1'b0;
      #1;
      check("async_reset", mk(0, 0, 0, 0, 0, 0, 0));
      #2;
      resetn = 1'b1;
      drive(32'd2, 1'b1, 1'b1, 1'b0);
      check("post_reset_first", mk(1, 1, 1, 0, 0, 0, 0));

      // random section against the model
      @(negedge clk);
      bus.din_valid = 1'b0; bus.clear = 1'b0;
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      model_reset();
      for (int n = 0; n < 600; n++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0: d = 32'd1 << $urandom_range(0, 31);
            1: d = 32'd0;
            2: d = $urandom;
            default: d = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
         endcase
         o = ($countones(d) == 1);
         if ($urandom_range(0, 19) == 0) o = ~o;
         v = ($urandom_range(0, 9) < 8);
         c = ($urandom_range(0, 29) == 0);
         model_step(d, o, v, c);
         drive(d, o, v, c);
         check($sformatf("random%0d", n), m_out);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
